// File: rtl/nn_weight_loader_pkg.sv
// Shared constants for the weight loader: default net geometry, FSM encodings
// and the helper that derives the flat weight count from the geometry.
package nn_weight_loader_pkg;

   localparam int NN_DATA_WIDTH  = 16;
   localparam int NN_INPUT_SIZE  = 4;
   localparam int NN_HIDDEN_SIZE = 4;
   localparam int NN_OUTPUT_SIZE = 2;

   localparam logic [1:0] NNL_STATE_IDLE   = 2'd0;
   localparam logic [1:0] NNL_STATE_LOAD   = 2'd1;
   localparam logic [1:0] NNL_STATE_COMMIT = 2'd2;

   // Hidden layer has one bias per neuron on top of its input weights; same for output.
   function automatic int nn_get_weights_size(input int n_in, input int n_hid, input int n_out);
      return n_hid * (n_in + 1) + n_out * (n_hid + 1);
   endfunction

endpackage

// File: rtl/nn_weight_loader_if.sv
// Word stream from the evolution controller (master) into the loader (slave).
interface nn_weight_loader_if #(
   parameter int DATA_WIDTH = 16
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_last;

   modport master (output in_valid, output in_data, output in_last, input in_ready);
   modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/nn_weight_shadow.sv
// Shadow copy of the weight genome: one indexed write port, full flat read-out.
module nn_weight_shadow #(
   parameter int DATA_WIDTH = 16,
   parameter int WORDS      = 30,
   parameter int IDX_W      = 5
) (
   input  logic                        clock,
   input  logic                        resetn,
   input  logic                        we,
   input  logic [IDX_W-1:0]            index,
   input  logic [DATA_WIDTH-1:0]       data,
   output logic [DATA_WIDTH*WORDS-1:0] shadow
);

   genvar gi;
   generate
      for (gi = 0; gi < WORDS; gi++) begin : g_word
         logic [DATA_WIDTH-1:0] word_q;
         logic [DATA_WIDTH-1:0] word_d;

         assign word_d = (we && (index == IDX_W'(gi))) ? data : word_q;

         // Each word holds its value until its own index is written.
         always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) word_q <= '0;
            else         word_q <= word_d;
         end

         assign shadow[DATA_WIDTH*gi +: DATA_WIDTH] = word_q;
      end
   endgenerate

endmodule

// File: rtl/nn_weight_loader.sv
// Double-buffered weight loader: framed word stream fills the shadow copy,
// which is copied to the active bus in one step only after a clean load.
module nn_weight_loader
   import nn_weight_loader_pkg::*;
#(
   parameter int DATA_WIDTH  = NN_DATA_WIDTH,
   parameter int INPUT_SIZE  = NN_INPUT_SIZE,
   parameter int HIDDEN_SIZE = NN_HIDDEN_SIZE,
   parameter int OUTPUT_SIZE = NN_OUTPUT_SIZE,
   localparam int WEIGHT_COUNT = nn_get_weights_size(INPUT_SIZE, HIDDEN_SIZE, OUTPUT_SIZE)
) (
   input  logic                               clock,
   input  logic                               resetn,
   input  logic                               start,
   input  logic                               abort,
   nn_weight_loader_if.slave                  in_if,
   output logic [DATA_WIDTH*WEIGHT_COUNT-1:0] weights,
   output logic                               weights_valid,
   output logic                               busy,
   output logic                               done,
   output logic                               error
);

   localparam int IDX_W = $clog2(WEIGHT_COUNT + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WEIGHT_COUNT - 1);

   logic [1:0]                         state_q, state_d;
   logic [IDX_W-1:0]                   index_q, index_d;
   logic [DATA_WIDTH*WEIGHT_COUNT-1:0] weights_q, weights_d;
   logic                               weights_valid_q, weights_valid_d;
   logic                               done_q, done_d;
   logic                               error_q, error_d;
   logic [DATA_WIDTH*WEIGHT_COUNT-1:0] shadow;
   logic                               accept;

   // Abort wins over any word presented in the same cycle.
   assign accept = (state_q == NNL_STATE_LOAD) && !abort && in_if.in_valid;

   nn_weight_shadow #(
      .DATA_WIDTH (DATA_WIDTH),
      .WORDS      (WEIGHT_COUNT),
      .IDX_W      (IDX_W)
   ) u_shadow (
      .clock  (clock),
      .resetn (resetn),
      .we     (accept),
      .index  (index_q),
      .data   (in_if.in_data),
      .shadow (shadow)
   );

   // Next-state: framing checks on each accepted word, commit copies shadow to active.
   always_comb begin
      state_d         = state_q;
      index_d         = index_q;
      weights_d       = weights_q;
      weights_valid_d = weights_valid_q;
      done_d          = 1'b0;
      error_d         = 1'b0;
      case (state_q)
         NNL_STATE_IDLE: begin
            if (start) begin
               state_d = NNL_STATE_LOAD;
               index_d = '0;
            end
         end
         NNL_STATE_LOAD: begin
            if (abort) begin
               state_d = NNL_STATE_IDLE;
            end else if (in_if.in_valid) begin
               if (index_q == LAST_IDX) begin
                  if (in_if.in_last) begin
                     state_d = NNL_STATE_COMMIT;
                  end else begin
                     state_d = NNL_STATE_IDLE;
                     error_d = 1'b1;
                  end
               end else if (in_if.in_last) begin
                  state_d = NNL_STATE_IDLE;
                  error_d = 1'b1;
               end else begin
                  index_d = index_q + 1'b1;
               end
            end
         end
         NNL_STATE_COMMIT: begin
            weights_d       = shadow;
            weights_valid_d = 1'b1;
            done_d          = 1'b1;
            state_d         = NNL_STATE_IDLE;
         end
         default: state_d = NNL_STATE_IDLE;
      endcase
   end

   // State, active copy and status pulses.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q         <= NNL_STATE_IDLE;
         index_q         <= '0;
         weights_q       <= '0;
         weights_valid_q <= 1'b0;
         done_q          <= 1'b0;
         error_q         <= 1'b0;
      end else begin
         state_q         <= state_d;
         index_q         <= index_d;
         weights_q       <= weights_d;
         weights_valid_q <= weights_valid_d;
         done_q          <= done_d;
         error_q         <= error_d;
      end
   end

   assign in_if.in_ready = (state_q == NNL_STATE_LOAD);
   assign weights        = weights_q;
   assign weights_valid  = weights_valid_q;
   assign busy           = (state_q != NNL_STATE_IDLE);
   assign done           = done_q;
   assign error          = error_q;

endmodule

// File: tb/tb_nn_weight_loader.sv
// Directed bench for nn_weight_loader: good loads, short/long genomes, abort, mid-load reset.
module tb_nn_weight_loader;
   import nn_weight_loader_pkg::*;

   localparam int DW = 16;
   localparam int WC = nn_get_weights_size(NN_INPUT_SIZE, NN_HIDDEN_SIZE, NN_OUTPUT_SIZE);

   logic            clock = 1'b0;
   logic            resetn = 1'b0;
   logic            start = 1'b0;
   logic            abort = 1'b0;
   logic [DW*WC-1:0] weights;
   logic            weights_valid, busy, done, error;

   nn_weight_loader_if #(.DATA_WIDTH(DW)) bus ();

   nn_weight_loader dut (
      .clock         (clock),
      .resetn        (resetn),
      .start         (start),
      .abort         (abort),
      .in_if         (bus.slave),
      .weights       (weights),
      .weights_valid (weights_valid),
      .busy          (busy),
      .done          (done),
      .error         (error)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0, err_cnt = 0, rdy_cnt = 0, overlap_cnt = 0;
   logic [DW-1:0] exp_w [WC];

   // Event counters sampled on the falling edge, away from the active edge.
   always @(negedge clock) begin
      if (done)          done_cnt++;
      if (error)         err_cnt++;
      if (bus.in_ready)  rdy_cnt++;
      if (done && error) overlap_cnt++;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_weights(input string tag);
      for (int k = 0; k < WC; k++)
         check_val($sformatf("%s[%0d]", tag, k), 32'(weights[DW*k +: DW]), 32'(exp_w[k]));
   endtask

   // Start cycle also presents a junk word with in_last: it must not be consumed.
   task automatic do_start();
      @(negedge clock);
      start        = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 16'hBAD0;
      bus.in_last  = 1'b1;
      @(negedge clock);
      start        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic send_word(input logic [DW-1:0] data, input logic last, input bit gaps);
      if (gaps) begin
         repeat ($urandom_range(0, 2)) begin
            bus.in_valid = 1'b0;
            @(negedge clock);
         end
      end
      bus.in_valid = 1'b1;
      bus.in_data  = data;
      bus.in_last  = last;
      @(negedge clock);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   int d0, e0, r0;

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.in_last  = 1'b0;

      // Reset values
      #1;
      check_val("rst_weights_zero", 32'(weights == '0), 32'd1);
      check_val("rst_weights_valid", 32'(weights_valid), 32'd0);
      check_val("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      repeat (2) @(negedge clock);
      resetn = 1'b1;
      repeat (2) @(negedge clock);
      $display("reset checked");

      // Good load 0x0100+k
      d0 = done_cnt; e0 = err_cnt; r0 = rdy_cnt;
      do_start();
      for (int k = 0; k < WC; k++) send_word(16'h0100 + 16'(k), k == WC - 1, 1'b0);
      check_val("commit_not_yet_done", 32'(done), 32'd0);
      check_val("commit_busy", 32'(busy), 32'd1);
      @(negedge clock);
      check_val("commit_done", 32'(done), 32'd1);
      check_val("commit_valid", 32'(weights_valid), 32'd1);
      check_val("commit_idle", 32'(busy), 32'd0);
      @(negedge clock);
      check_val("done_one_cycle", 32'(done), 32'd0);
      check_val("good_ready_cycles", 32'(rdy_cnt - r0), 32'd30);
      check_val("good_done_count", 32'(done_cnt - d0), 32'd1);
      check_val("good_err_count", 32'(err_cnt - e0), 32'd0);
      for (int k = 0; k < WC; k++) exp_w[k] = 16'h0100 + 16'(k);
      check_weights("good_w");
      $display("load 0x0100+k checked");

      // Short genome: in_last on the 10th word
      d0 = done_cnt; e0 = err_cnt;
      do_start();
      for (int k = 0; k < 10; k++) send_word(16'h0300 + 16'(k), k == 9, 1'b0);
      check_val("short_error_pulse", 32'(error), 32'd1);
      check_val("short_idle", 32'(busy), 32'd0);
      @(negedge clock);
      check_val("short_error_one_cycle", 32'(error), 32'd0);
      repeat (2) @(negedge clock);
      check_val("short_err_count", 32'(err_cnt - e0), 32'd1);
      check_val("short_done_count", 32'(done_cnt - d0), 32'd0);
      check_val("short_valid_kept", 32'(weights_valid), 32'd1);
      check_weights("short_w");
      $display("short genome checked");

      // Long genome: no in_last on the 30th word
      d0 = done_cnt; e0 = err_cnt;
      do_start();
      for (int k = 0; k < WC; k++) send_word(16'h0400 + 16'(k), 1'b0, 1'b0);
      check_val("long_error_pulse", 32'(error), 32'd1);
      check_val("long_idle", 32'(busy), 32'd0);
      repeat (2) @(negedge clock);
      check_val("long_err_count", 32'(err_cnt - e0), 32'd1);
      check_val("long_done_count", 32'(done_cnt - d0), 32'd0);
      check_weights("long_w");
      $display("long genome checked");

      // All-ones load after the error
      d0 = done_cnt; e0 = err_cnt;
      do_start();
      for (int k = 0; k < WC; k++) send_word(16'hFFFF, k == WC - 1, 1'b0);
      repeat (3) @(negedge clock);
      check_val("ffff_done_count", 32'(done_cnt - d0), 32'd1);
      check_val("ffff_err_count", 32'(err_cnt - e0), 32'd0);
      for (int k = 0; k < WC; k++) exp_w[k] = 16'hFFFF;
      check_weights("ffff_w");
      $display("all-ones load checked");

      // Gapped load aborted after word 15, with a word presented alongside abort
      d0 = done_cnt; e0 = err_cnt;
      do_start();
      for (int k = 0; k < 15; k++) send_word(16'h0500 + 16'(k), 1'b0, 1'b1);
      abort        = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 16'hDEAD;
      bus.in_last  = 1'b1;
      @(negedge clock);
      abort        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      check_val("abort_ready_drop", 32'(bus.in_ready), 32'd0);
      check_val("abort_idle", 32'(busy), 32'd0);
      check_val("abort_no_error", 32'(error), 32'd0);
      repeat (2) @(negedge clock);
      check_val("abort_err_count", 32'(err_cnt - e0), 32'd0);
      check_val("abort_done_count", 32'(done_cnt - d0), 32'd0);
      check_weights("abort_w");
      d0 = done_cnt; e0 = err_cnt;
      do_start();
      for (int k = 0; k < WC; k++) send_word(16'h0200 + 16'(k), k == WC - 1, 1'b1);
      repeat (3) @(negedge clock);
      check_val("restart_done_count", 32'(done_cnt - d0), 32'd1);
      check_val("restart_err_count", 32'(err_cnt - e0), 32'd0);
      for (int k = 0; k < WC; k++) exp_w[k] = 16'h0200 + 16'(k);
      check_weights("restart_w");
      $display("abort and restart checked");

      // Reset mid-load at word 12
      do_start();
      for (int k = 0; k < 12; k++) send_word(16'h0600 + 16'(k), 1'b0, 1'b0);
      resetn = 1'b0;
      #1;
      check_val("midrst_weights_zero", 32'(weights == '0), 32'd1);
      check_val("midrst_valid", 32'(weights_valid), 32'd0);
      check_val("midrst_in_ready", 32'(bus.in_ready), 32'd0);
      check_val("midrst_busy", 32'(busy), 32'd0);
      check_val("midrst_done", 32'(done), 32'd0);
      check_val("midrst_error", 32'(error), 32'd0);
      @(negedge clock);
      resetn = 1'b1;
      repeat (2) @(negedge clock);
      check_val("postrst_valid", 32'(weights_valid), 32'd0);
      $display("mid-load reset checked");

      check_val("done_error_overlap", 32'(overlap_cnt), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/nn_weight_loader.md
Name: nn_weight_loader

Overview:
- Streams the network's weight genome in word-by-word over a valid/ready interface and assembles the flat weight bus consumed by the neural-net datapath.
- Double-buffered: words fill a shadow copy. The active bus changes atomically, only after a complete, correctly framed load.
- Sits between the evolution controller (or host) and the net, so a new individual can be loaded while the net keeps evaluating the previous one.

Parameters:
- DATA_WIDTH, `NN_DATA_WIDTH (16): word width, fixed-point with DATA_WIDTH/2 fraction bits.
- INPUT_SIZE, `NN_INPUT_SIZE (4): net inputs.
- HIDDEN_SIZE, `NN_HIDDEN_SIZE (4): hidden neurons.
- OUTPUT_SIZE, `NN_OUTPUT_SIZE (2): output neurons.
- WEIGHT_COUNT, `NN_GET_WEIGHTS_SIZE(INPUT_SIZE,HIDDEN_SIZE,OUTPUT_SIZE): derived, must not be overridden; equals HIDDEN_SIZE*(INPUT_SIZE+1) + OUTPUT_SIZE*(HIDDEN_SIZE+1), which is 30 at defaults.

Ports:
- clock, in, 1: single clock; all state on rising edge.
- resetn, in, 1: asynchronous, active-low reset.
- start, in, 1: begin a new load; sampled only in IDLE.
- abort, in, 1: discard an in-progress load.
- in_valid, in, 1: in_data/in_last valid.
- in_ready, out, 1: loader accepts a word this cycle.
- in_data, in, DATA_WIDTH: weight word.
- in_last, in, 1: marks final word of the genome.
- weights, out, DATA_WIDTH*WEIGHT_COUNT: active weight bus; word k occupies bits [DATA_WIDTH*(k+1)-1 : DATA_WIDTH*k].
- weights_valid, out, 1: active bus holds a committed genome.
- busy, out, 1: state != IDLE.
- done, out, 1: one-cycle pulse on commit.
- error, out, 1: one-cycle pulse on framing error.

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE, index=0.
  - weights=0, shadow=0.
  - weights_valid=0, in_ready=0, done=0, error=0.
- States: IDLE, LOAD, COMMIT.
- IDLE:
  - in_ready=0.
  - start=1 → LOAD, index<=0.
  - in_valid in IDLE is ignored; no word is consumed.
- LOAD:
  - in_ready=1 (combinational from state; not dependent on in_valid).
  - A word is accepted on each edge with in_valid&&in_ready: shadow[index]<=in_data, index<=index+1.
  - Accepted word with index==WEIGHT_COUNT-1 and in_last=1 → COMMIT.
  - Accepted word with in_last=1 and index<WEIGHT_COUNT-1 (short genome) → error pulse next cycle, → IDLE.
  - Accepted word with index==WEIGHT_COUNT-1 and in_last=0 (long genome) → error pulse next cycle, → IDLE.
  - On any error, the active weights and weights_valid are unchanged.
- COMMIT (exactly one cycle):
  - in_ready=0.
  - On its edge: weights<=shadow, weights_valid<=1, done<=1 for one cycle, → IDLE.
  - Latency: the final word is accepted at edge t; weights update and done rises at edge t+1.
- abort:
  - Highest priority in LOAD: → IDLE on that edge, no word accepted that cycle, no error pulse, active weights untouched.
  - abort in IDLE or COMMIT is ignored; commit always completes.
- start while busy is ignored.
- Shadow is not cleared between loads. Every committed genome has all WEIGHT_COUNT words freshly written, so stale contents are never exposed.
- Index width: clog2(WEIGHT_COUNT+1); no wrap, since reaching the last index always exits LOAD.
- Words are stored bit-exact; no arithmetic or saturation is applied.
- Simultaneous start and in_valid in IDLE: transition to LOAD only; the word is taken on a later cycle.
- done and error are never asserted in the same cycle.

Decomposition:
- Shared constants header (constants.h):
  - `NN_DATA_WIDTH, `NN_INPUT_SIZE, `NN_HIDDEN_SIZE, `NN_OUTPUT_SIZE, `NN_GET_WEIGHTS_SIZE.
  - New: `NNL_STATE_IDLE/LOAD/COMMIT encodings (2 bits).
- One sub-module: nn_weight_shadow.
  - Indexed write port (we, index, data); full flat read-out.
  - Resettable to zero.
  - The loader instantiates it for the shadow copy and holds the active copy as a plain register.

Test Plan:
- Reset → weights_valid=0, weights=0, in_ready=0, busy=0.
- start, then 30 words 0x0100+k (k=0..29), in_last on k=29, in_valid held high → in_ready high 30 cycles; done pulses one cycle after the 30th accept; weights word k = 0x0100+k; weights_valid=1.
- After a good load, start again and send 10 words with in_last on the 10th → error pulses once, done never pulses, weights still hold the prior 0x0100+k values.
- Send 30 words with in_last=0 on the 30th → error pulse, back to IDLE, weights unchanged; a following correct load of 0xFFFF words commits all-0xFFFF.
- Random in_valid gaps (50%) during a load, plus abort asserted after word 15 → no error and no done; in_ready drops the next cycle; a restarted load completes correctly.
- resetn pulsed low mid-load (word 12) → all outputs return to reset values immediately; weights_valid=0.
